// File: rtl/alu_ctl_stage_if.sv
// alu_ctl_stage_if
//   Bundles the ID-side inputs and the registered EX-side outputs of the
//   ALU-control stage. The slave modport is the stage itself. The master
//   modport is whatever drives the ID side and observes the outputs.
interface alu_ctl_stage_if #(
  parameter int CNT_W = 8
) ();

  // ID-side instruction information
  logic             in_valid;
  logic [1:0]       aluop;
  logic [5:0]       funct;
  logic [5:0]       opcode;

  // Pipeline control
  logic             stall;
  logic             flush;
  logic             clr_sticky;

  // Registered EX-side results
  logic [3:0]       ctl;
  logic             ctl_valid;
  logic             illegal;
  logic             illegal_sticky;
  logic [CNT_W-1:0] illegal_cnt;

  modport slave (
    input  in_valid, aluop, funct, opcode,
    input  stall, flush, clr_sticky,
    output ctl, ctl_valid, illegal, illegal_sticky, illegal_cnt
  );

  modport master (
    output in_valid, aluop, funct, opcode,
    output stall, flush, clr_sticky,
    input  ctl, ctl_valid, illegal, illegal_sticky, illegal_cnt
  );

endinterface

// File: rtl/alu_ctl_stage.sv
// alu_ctl_stage
//   Registered ALU-control encoder sitting at the ID->EX boundary.
//   - Decodes aluop plus funct/opcode into the 4-bit ALU control code.
//   - Holds the code in a pipeline register with stall and flush.
//   - Flags undecodable operations. Keeps a sticky flag and a saturating
//     count of the ones that were actually captured.
//   Optional feature macro: ALU_CTL_XORNOR_EN
//     defined   -> funct 100110/100111 and opcode 001110 decode to xor/nor
//     undefined -> those encodings are treated as undecodable
module alu_ctl_stage #(
  parameter int         CNT_W    = 8,
  parameter logic [3:0] IDLE_CTL = 4'b1111
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_ctl_stage_if.slave     bus
);

  // ALU control codes
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_SLT = 4'b0111;
`ifdef ALU_CTL_XORNOR_EN
  localparam logic [3:0] CTL_XOR = 4'b1101;
  localparam logic [3:0] CTL_NOR = 4'b1100;
`endif

  // Main-decoder aluop classes
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_RTYP = 2'b10;
  localparam logic [1:0] ALUOP_ITYP = 2'b11;

  // Counter saturation value and increment
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Pipeline register state
  logic [3:0]       ctl_q,       ctl_d;
  logic             ctl_valid_q, ctl_valid_d;
  logic             illegal_q,   illegal_d;
  logic             sticky_q,    sticky_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  // Combinational decode results
  logic [3:0]       dec_ctl;
  logic             dec_illegal;
  logic             load_illegal;

  // Decode aluop/funct/opcode into a control code, or mark it undecodable
  always_comb begin
    dec_ctl     = IDLE_CTL;
    dec_illegal = 1'b0;
    case (bus.aluop)
      ALUOP_ADD: dec_ctl = CTL_ADD;
      ALUOP_SUB: dec_ctl = CTL_SUB;
      ALUOP_RTYP: begin
        case (bus.funct)
          6'b100000,
          6'b100001: dec_ctl = CTL_ADD;
          6'b100010,
          6'b100011: dec_ctl = CTL_SUB;
          6'b100100: dec_ctl = CTL_AND;
          6'b100101: dec_ctl = CTL_OR;
          6'b101010: dec_ctl = CTL_SLT;
`ifdef ALU_CTL_XORNOR_EN
          6'b100110: dec_ctl = CTL_XOR;
          6'b100111: dec_ctl = CTL_NOR;
`endif
          default: begin
            dec_ctl     = IDLE_CTL;
            dec_illegal = 1'b1;
          end
        endcase
      end
      ALUOP_ITYP: begin
        case (bus.opcode)
          6'b001000,
          6'b001001: dec_ctl = CTL_ADD;
          6'b001100: dec_ctl = CTL_AND;
          6'b001101: dec_ctl = CTL_OR;
          6'b001010: dec_ctl = CTL_SLT;
`ifdef ALU_CTL_XORNOR_EN
          6'b001110: dec_ctl = CTL_XOR;
`endif
          default: begin
            dec_ctl     = IDLE_CTL;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctl     = IDLE_CTL;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Next-state for the pipeline register (flush > stall > load) and for the
  // illegal-op bookkeeping
  always_comb begin
    ctl_d       = ctl_q;
    ctl_valid_d = ctl_valid_q;
    illegal_d   = illegal_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;

    // Only an illegal op that actually lands in the register is counted.
    // A flushed or stalled one never reaches EX.
    load_illegal = !bus.flush && !bus.stall && bus.in_valid && dec_illegal;

    if (bus.flush) begin
      ctl_d       = IDLE_CTL;
      ctl_valid_d = 1'b0;
      illegal_d   = 1'b0;
    end else if (!bus.stall) begin
      ctl_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        ctl_d     = dec_ctl;
        illegal_d = dec_illegal;
      end else begin
        ctl_d     = IDLE_CTL;
        illegal_d = 1'b0;
      end
    end

    if (bus.clr_sticky) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end

    // A set in the same cycle as a clear wins. The count restarts at one.
    if (load_illegal) begin
      sticky_d = 1'b1;
      if (bus.clr_sticky) begin
        cnt_d = CNT_ONE;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q       <= IDLE_CTL;
      ctl_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ctl_q       <= ctl_d;
      ctl_valid_q <= ctl_valid_d;
      illegal_q   <= illegal_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.ctl            = ctl_q;
  assign bus.ctl_valid      = ctl_valid_q;
  assign bus.illegal        = illegal_q;
  assign bus.illegal_sticky = sticky_q;
  assign bus.illegal_cnt    = cnt_q;

endmodule

// File: tb/tb_alu_ctl_stage.sv
// tb_alu_ctl_stage
//   Table-driven directed bench for alu_ctl_stage, built with CNT_W=2 so that
//   counter saturation is reachable. Expectations depend on ALU_CTL_XORNOR_EN.
module tb_alu_ctl_stage;

  localparam int CNT_W = 2;

  logic clk;
  logic rst_n;

  alu_ctl_stage_if #(.CNT_W(CNT_W)) bus ();

  alu_ctl_stage #(.CNT_W(CNT_W), .IDLE_CTL(4'b1111)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [5:0] opcode;
    logic       st;
    logic       fl;
    logic       clr;
    logic [3:0] e_ctl;
    logic       e_valid;
    logic       e_ill;
    logic       e_sticky;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic v, input logic [1:0] a, input logic [5:0] f,
                     input logic [5:0] o, input logic st, input logic fl,
                     input logic clr, input logic [3:0] ec, input logic ev,
                     input logic ei, input logic es, input logic [1:0] en);
    vec_t t;
    t.v = v; t.aluop = a; t.funct = f; t.opcode = o; t.st = st; t.fl = fl;
    t.clr = clr; t.e_ctl = ec; t.e_valid = ev; t.e_ill = ei;
    t.e_sticky = es; t.e_cnt = en;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [5:0] f,
                       input logic [5:0] o, input logic st, input logic fl,
                       input logic clr);
    bus.in_valid   = v;
    bus.aluop      = a;
    bus.funct      = f;
    bus.opcode     = o;
    bus.stall      = st;
    bus.flush      = fl;
    bus.clr_sticky = clr;
  endtask

  task automatic check(input string name, input logic [3:0] ec, input logic ev,
                       input logic ei, input logic es, input logic [1:0] en);
    logic [8:0] act, exp;
    act = {bus.ctl, bus.ctl_valid, bus.illegal, bus.illegal_sticky, bus.illegal_cnt};
    exp = {ec, ev, ei, es, en};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ctl=%b valid=%b ill=%b sticky=%b cnt=%0d, expected ctl=%b valid=%b ill=%b sticky=%b cnt=%0d",
               name, bus.ctl, bus.ctl_valid, bus.illegal, bus.illegal_sticky,
               bus.illegal_cnt, ec, ev, ei, es, en);
    end else begin
      $display("ok   %s: ctl=%b valid=%b ill=%b sticky=%b cnt=%0d",
               name, bus.ctl, bus.ctl_valid, bus.illegal, bus.illegal_sticky,
               bus.illegal_cnt);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Vector table: inputs, then expected outputs one edge later
    //   v  aluop  funct      opcode     st fl clr  ctl      vld ill stk cnt
    add(1, 2'b00, 6'b000000, 6'b000000, 0, 0, 0, 4'b0010, 1, 0, 0, 2'd0);
    add(1, 2'b01, 6'b000000, 6'b000000, 0, 0, 0, 4'b0110, 1, 0, 0, 2'd0);
    add(1, 2'b10, 6'b100010, 6'b000000, 0, 0, 0, 4'b0110, 1, 0, 0, 2'd0);
    add(1, 2'b11, 6'b000000, 6'b001010, 0, 0, 0, 4'b0111, 1, 0, 0, 2'd0);
    add(1, 2'b10, 6'b100000, 6'b000000, 0, 0, 0, 4'b0010, 1, 0, 0, 2'd0);
    add(1, 2'b10, 6'b100001, 6'b000000, 0, 0, 0, 4'b0010, 1, 0, 0, 2'd0);
    add(1, 2'b10, 6'b100011, 6'b000000, 0, 0, 0, 4'b0110, 1, 0, 0, 2'd0);
    add(1, 2'b10, 6'b100100, 6'b000000, 0, 0, 0, 4'b0000, 1, 0, 0, 2'd0);
    add(1, 2'b10, 6'b100101, 6'b000000, 0, 0, 0, 4'b0001, 1, 0, 0, 2'd0);
    add(1, 2'b10, 6'b101010, 6'b000000, 0, 0, 0, 4'b0111, 1, 0, 0, 2'd0);
    add(1, 2'b11, 6'b000000, 6'b001000, 0, 0, 0, 4'b0010, 1, 0, 0, 2'd0);
    add(1, 2'b11, 6'b000000, 6'b001001, 0, 0, 0, 4'b0010, 1, 0, 0, 2'd0);
    add(1, 2'b11, 6'b000000, 6'b001100, 0, 0, 0, 4'b0000, 1, 0, 0, 2'd0);
    add(1, 2'b11, 6'b000000, 6'b001101, 0, 0, 0, 4'b0001, 1, 0, 0, 2'd0);
    // bubble: decodable funct but not valid
    add(0, 2'b10, 6'b100100, 6'b000000, 0, 0, 0, 4'b1111, 0, 0, 0, 2'd0);
    // illegal funct and illegal opcode
    add(1, 2'b10, 6'b111111, 6'b000000, 0, 0, 0, 4'b1111, 1, 1, 1, 2'd1);
    add(1, 2'b11, 6'b000000, 6'b000000, 0, 0, 0, 4'b1111, 1, 1, 1, 2'd2);
    // clear together with a legal load
    add(1, 2'b00, 6'b000000, 6'b000000, 0, 0, 1, 4'b0010, 1, 0, 0, 2'd0);
    // load add, stall 3 cycles while funct changes to and, then release
    add(1, 2'b10, 6'b100000, 6'b000000, 0, 0, 0, 4'b0010, 1, 0, 0, 2'd0);
    add(1, 2'b10, 6'b100100, 6'b000000, 1, 0, 0, 4'b0010, 1, 0, 0, 2'd0);
    add(1, 2'b10, 6'b100100, 6'b000000, 1, 0, 0, 4'b0010, 1, 0, 0, 2'd0);
    add(1, 2'b10, 6'b100100, 6'b000000, 1, 0, 0, 4'b0010, 1, 0, 0, 2'd0);
    add(1, 2'b10, 6'b100100, 6'b000000, 0, 0, 0, 4'b0000, 1, 0, 0, 2'd0);
    // illegal captured, then held by stall without recounting
    add(1, 2'b10, 6'b111111, 6'b000000, 0, 0, 0, 4'b1111, 1, 1, 1, 2'd1);
    add(1, 2'b10, 6'b111111, 6'b000000, 1, 0, 0, 4'b1111, 1, 1, 1, 2'd1);
    add(0, 2'b10, 6'b100000, 6'b000000, 1, 0, 0, 4'b1111, 1, 1, 1, 2'd1);
    // stall+flush with illegal funct: bubble, not counted
    add(1, 2'b10, 6'b111111, 6'b000000, 1, 1, 0, 4'b1111, 0, 0, 1, 2'd1);
    // plain flush over a valid add
    add(1, 2'b00, 6'b000000, 6'b000000, 0, 1, 0, 4'b1111, 0, 0, 1, 2'd1);
    add(1, 2'b00, 6'b000000, 6'b000000, 0, 0, 0, 4'b0010, 1, 0, 1, 2'd1);
    add(0, 2'b00, 6'b000000, 6'b000000, 0, 0, 1, 4'b1111, 0, 0, 0, 2'd0);
    // saturation at 3, then clear racing a 6th illegal load
    add(1, 2'b10, 6'b111111, 6'b000000, 0, 0, 0, 4'b1111, 1, 1, 1, 2'd1);
    add(1, 2'b10, 6'b111111, 6'b000000, 0, 0, 0, 4'b1111, 1, 1, 1, 2'd2);
    add(1, 2'b10, 6'b111111, 6'b000000, 0, 0, 0, 4'b1111, 1, 1, 1, 2'd3);
    add(1, 2'b10, 6'b111111, 6'b000000, 0, 0, 0, 4'b1111, 1, 1, 1, 2'd3);
    add(1, 2'b10, 6'b111111, 6'b000000, 0, 0, 0, 4'b1111, 1, 1, 1, 2'd3);
    add(1, 2'b10, 6'b111111, 6'b000000, 0, 0, 1, 4'b1111, 1, 1, 1, 2'd1);
    add(1, 2'b00, 6'b000000, 6'b000000, 0, 0, 1, 4'b0010, 1, 0, 0, 2'd0);

    // Reset held for two edges
    drive(1, 2'b10, 6'b111111, 6'b000000, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    check("reset", 4'b1111, 0, 0, 0, 2'd0);
    rst_n = 1'b1;
    drive(0, 2'b00, 6'b000000, 6'b000000, 0, 0, 0);
    tick();
    check("idle_after_reset", 4'b1111, 0, 0, 0, 2'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].aluop, vecs[i].funct, vecs[i].opcode,
            vecs[i].st, vecs[i].fl, vecs[i].clr);
      tick();
      check($sformatf("vec%0d", i), vecs[i].e_ctl, vecs[i].e_valid,
            vecs[i].e_ill, vecs[i].e_sticky, vecs[i].e_cnt);
    end

    // Optional xor/nor encodings; sticky and count start cleared here
    drive(1, 2'b10, 6'b100111, 6'b000000, 0, 0, 0);
    tick();
`ifdef ALU_CTL_XORNOR_EN
    check("nor_funct", 4'b1100, 1, 0, 0, 2'd0);
`else
    check("nor_funct", 4'b1111, 1, 1, 1, 2'd1);
`endif
    drive(1, 2'b10, 6'b100110, 6'b000000, 0, 0, 0);
    tick();
`ifdef ALU_CTL_XORNOR_EN
    check("xor_funct", 4'b1101, 1, 0, 0, 2'd0);
`else
    check("xor_funct", 4'b1111, 1, 1, 1, 2'd2);
`endif
    drive(1, 2'b11, 6'b000000, 6'b001110, 0, 0, 0);
    tick();
`ifdef ALU_CTL_XORNOR_EN
    check("xor_opcode", 4'b1101, 1, 0, 0, 2'd0);
`else
    check("xor_opcode", 4'b1111, 1, 1, 1, 2'd3);
`endif

    // Reset asserted during stall and flush: reset values win
    drive(1, 2'b10, 6'b111111, 6'b000000, 1, 1, 0);
    rst_n = 1'b0;
    tick();
    check("reset_mid_stall_flush", 4'b1111, 0, 0, 0, 2'd0);
    rst_n = 1'b1;
    drive(1, 2'b11, 6'b000000, 6'b001101, 0, 0, 0);
    tick();
    check("load_after_reset", 4'b0001, 1, 0, 0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
